rib_ex_bridge: RTL and testbench

- Sits directly downstream of the core's data port (rib_ex_addr/data/req/we/ack). Converts the core's level-held request / single-cycle ack handshake into a registered valid/ready request plus response-valid slave interface.
- Tracks one outstanding transaction and produces a bus hold flag for the core's hold_flag_rib input.
- Bounds every transaction with a timeout that completes it with an error flag.

---
 rtl/rib_ex_bridge.sv | 156 +++++++++++++++
 tb/tb_rib_ex_bridge.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/rib_ex_bridge.sv
// rib_ex_bridge: converts the core data port's level-held req / one-cycle ack
// handshake into a registered valid/ready request plus response-valid slave
// interface, with a single outstanding transaction and a bounded timeout.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   req_i, we_i              core request (held until ack_o), write enable
//   addr_i, wdata_i          core address / write data
//   ack_o, rdata_o, err_o    one-cycle completion, read data, timeout error
//   hold_o                   bus hold flag to the core (combinational)
//   s_valid_o, s_ready_i     slave request handshake
//   s_we_o, s_addr_o,
//   s_wdata_o                slave request payload (latched at issue)
//   s_rvalid_i, s_rdata_i    slave read response
module rib_ex_bridge #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              ack_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              err_o,
    output logic              hold_o,
    output logic              s_valid_o,
    input  logic              s_ready_i,
    output logic              s_we_o,
    output logic [ADDR_W-1:0] s_addr_o,
    output logic [DATA_W-1:0] s_wdata_o,
    input  logic              s_rvalid_i,
    input  logic [DATA_W-1:0] s_rdata_i
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
    localparam logic [1:0] ST_ACK  = 2'd3;

    logic [1:0]        state_q,   state_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic              s_valid_q, s_valid_d;
    logic              s_we_q,    s_we_d;
    logic [ADDR_W-1:0] s_addr_q,  s_addr_d;
    logic [DATA_W-1:0] s_wdata_q, s_wdata_d;
    logic              ack_q,     ack_d;
    logic              err_q,     err_d;
    logic [DATA_W-1:0] rdata_q,   rdata_d;
    logic              timeout_hit;

    // Last permitted cycle in REQ+RESP
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            s_valid_q <= 1'b0;
            s_we_q    <= 1'b0;
            s_addr_q  <= '0;
            s_wdata_q <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            s_valid_q <= s_valid_d;
            s_we_q    <= s_we_d;
            s_addr_q  <= s_addr_d;
            s_wdata_q <= s_wdata_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
        end
    end

    // Next-state and registered-output logic; ack/err/rdata default to 0 so
    // they pulse for exactly the ACK cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        s_valid_d = s_valid_q;
        s_we_d    = s_we_q;
        s_addr_d  = s_addr_q;
        s_wdata_d = s_wdata_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        rdata_d   = '0;

        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    s_we_d    = we_i;
                    s_addr_d  = addr_i;
                    s_wdata_d = wdata_i;
                    s_valid_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_REQ;
                end
            end
            ST_REQ: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (s_ready_i && s_we_q) begin
                    // Accepted write completes the transaction; beats timeout
                    s_valid_d = 1'b0;
                    ack_d     = 1'b1;
                    state_d   = ST_ACK;
                end else if (timeout_hit) begin
                    // A read accepted on the last cycle still has no data
                    s_valid_d = 1'b0;
                    ack_d     = 1'b1;
                    err_d     = 1'b1;
                    state_d   = ST_ACK;
                end else if (s_ready_i) begin
                    s_valid_d = 1'b0;
                    state_d   = ST_RESP;
                end
            end
            ST_RESP: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (s_rvalid_i) begin
                    rdata_d = s_rdata_i;
                    ack_d   = 1'b1;
                    state_d = ST_ACK;
                end else if (timeout_hit) begin
                    ack_d   = 1'b1;
                    err_d   = 1'b1;
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign ack_o     = ack_q;
    assign err_o     = err_q;
    assign rdata_o   = rdata_q;
    assign s_valid_o = s_valid_q;
    assign s_we_o    = s_we_q;
    assign s_addr_o  = s_addr_q;
    assign s_wdata_o = s_wdata_q;
    assign hold_o    = req_i & ~ack_q;

endmodule

// File: tb/tb_rib_ex_bridge.sv
// Testbench for rib_ex_bridge: directed and randomized transactions checked
// cycle by cycle against a timing model derived from the handshake rules.
module tb_rib_ex_bridge;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int          T       = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              req_i = 1'b0;
    logic              we_i = 1'b0;
    logic [ADDR_W-1:0] addr_i = '0;
    logic [DATA_W-1:0] wdata_i = '0;
    logic              ack_o;
    logic [DATA_W-1:0] rdata_o;
    logic              err_o;
    logic              hold_o;
    logic              s_valid_o;
    logic              s_ready_i = 1'b0;
    logic              s_we_o;
    logic [ADDR_W-1:0] s_addr_o;
    logic [DATA_W-1:0] s_wdata_o;
    logic              s_rvalid_i = 1'b0;
    logic [DATA_W-1:0] s_rdata_i = '0;

    int n_vec = 0;
    int n_err = 0;

    rib_ex_bridge #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(T),
        .CNT_W  (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_i     (req_i),
        .we_i      (we_i),
        .addr_i    (addr_i),
        .wdata_i   (wdata_i),
        .ack_o     (ack_o),
        .rdata_o   (rdata_o),
        .err_o     (err_o),
        .hold_o    (hold_o),
        .s_valid_o (s_valid_o),
        .s_ready_i (s_ready_i),
        .s_we_o    (s_we_o),
        .s_addr_o  (s_addr_o),
        .s_wdata_o (s_wdata_o),
        .s_rvalid_i(s_rvalid_i),
        .s_rdata_i (s_rdata_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One transaction; cycle 0 is the IDLE cycle where req_i first rises.
    // Slave pulses s_ready_i at cycle 1+r and (reads) s_rvalid_i at cycle 2+r+v.
    // Time is counted from the first REQ cycle (t=0); the transaction may
    // finish at t <= T-1, otherwise it is forced out at t = T-1 with an error.
    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int r, input int v,
                           input bit late_rv, input bit keep);
        int          tc;
        int          ack_cyc;
        int          sv_end;
        bit          ok;
        logic [31:0] exp_rd;
        tc      = we ? r : r + 1 + v;
        ok      = (tc <= T - 1);
        ack_cyc = ok ? tc + 2 : T + 1;
        sv_end  = 1 + ((r < T - 1) ? r : T - 1);
        exp_rd  = (ok && !we) ? rdata : 32'h0;
        for (int cyc = 0; cyc <= ack_cyc + 3; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin
                req_i = 1'b1; we_i = we; addr_i = addr; wdata_i = wdata;
            end else if (cyc <= ack_cyc) begin
                // Core inputs wander mid-transaction; slave side must not follow
                we_i = 1'($urandom); addr_i = $urandom; wdata_i = $urandom;
            end else begin
                req_i = 1'b0;
            end
            s_ready_i  = (cyc == 1 + r);
            s_rvalid_i = (!we && cyc == 2 + r + v) || (late_rv && cyc == ack_cyc + 1);
            s_rdata_i  = (!we && cyc == 2 + r + v) ? rdata : $urandom;
            #1;
            chk("ack", 32'(ack_o), 32'(cyc == ack_cyc));
            chk("s_valid", 32'(s_valid_o), 32'(cyc >= 1 && cyc <= sv_end));
            if (cyc >= 1 && cyc <= sv_end) begin
                chk("s_addr", s_addr_o, addr);
                chk("s_wdata", s_wdata_o, wdata);
                chk("s_we", 32'(s_we_o), 32'(we));
            end
            chk("hold", 32'(hold_o), 32'(req_i && cyc != ack_cyc));
            chk("err", 32'(err_o), 32'(cyc == ack_cyc && !ok));
            chk("rdata", rdata_o, (cyc == ack_cyc) ? exp_rd : 32'h0);
            if (keep && cyc == ack_cyc) break;
        end
        s_ready_i  = 1'b0;
        s_rvalid_i = 1'b0;
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_ack", 32'(ack_o), 32'h0);
        chk("rst_valid", 32'(s_valid_o), 32'h0);
        chk("rst_err", 32'(err_o), 32'h0);
        chk("rst_rdata", rdata_o, 32'h0);
        chk("rst_addr", s_addr_o, 32'h0);
        chk("rst_hold", 32'(hold_o), 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Minimum-latency write
        run_txn(1'b1, 32'h1000_0004, 32'hDEAD_BEEF, 32'h0, 0, 0, 1'b0, 1'b0);
        // Read with delayed ready and response
        run_txn(1'b0, 32'h2000_0000, 32'h0, 32'h1234_5678, 3, 1, 1'b0, 1'b0);
        // Slave never ready: timeout, late rvalid ignored
        run_txn(1'b0, 32'h3000_0010, 32'h0, 32'h5555_AAAA, 100, 0, 1'b1, 1'b0);
        // rvalid on the last permitted cycle: completion wins
        run_txn(1'b0, 32'h3000_0020, 32'h0, 32'hCAFE_F00D, 0, 6, 1'b0, 1'b0);
        // Write accepted on the last cycle, then one that times out
        run_txn(1'b1, 32'h4000_0000, 32'h0BAD_F00D, 32'h0, 7, 0, 1'b0, 1'b0);
        run_txn(1'b1, 32'h4000_0004, 32'h1111_2222, 32'h0, 8, 0, 1'b0, 1'b0);
        // Back-to-back read then write with req_i held across ACK
        run_txn(1'b0, 32'h5000_0000, 32'h0, 32'h8765_4321, 0, 0, 1'b0, 1'b1);
        run_txn(1'b1, 32'h5000_0008, 32'hA5A5_5A5A, 32'h0, 0, 0, 1'b0, 1'b0);

        // Reset while in REQ: s_valid_o drops without waiting for a clock
        @(negedge clk);
        req_i = 1'b1; we_i = 1'b0; addr_i = 32'h6000_0000;
        @(negedge clk); #1;
        chk("req_valid_pre", 32'(s_valid_o), 32'h1);
        rst = 1'b0; #1;
        chk("req_rst_valid", 32'(s_valid_o), 32'h0);
        chk("req_rst_ack", 32'(ack_o), 32'h0);
        @(negedge clk);
        rst = 1'b1; req_i = 1'b0;

        // Reset while in RESP
        @(negedge clk);
        req_i = 1'b1; we_i = 1'b0; addr_i = 32'h7000_0000;
        @(negedge clk);
        s_ready_i = 1'b1;
        @(negedge clk);
        s_ready_i = 1'b0; #1;
        rst = 1'b0; #1;
        chk("resp_rst_valid", 32'(s_valid_o), 32'h0);
        chk("resp_rst_ack", 32'(ack_o), 32'h0);
        chk("resp_rst_err", 32'(err_o), 32'h0);
        @(negedge clk);
        rst = 1'b1; req_i = 1'b0;
        // A stray rvalid after release must not complete anything (IDLE)
        s_rvalid_i = 1'b1; s_rdata_i = 32'hFFFF_FFFF;
        @(negedge clk);
        s_rvalid_i = 1'b0; #1;
        chk("post_rst_ack", 32'(ack_o), 32'h0);
        chk("post_rst_rdata", rdata_o, 32'h0);
        run_txn(1'b0, 32'h7000_0004, 32'h0, 32'h0F0F_F0F0, 1, 2, 1'b0, 1'b0);

        // Randomized transactions
        for (int i = 0; i < 40; i++) begin
            run_txn(1'($urandom), $urandom, $urandom, $urandom,
                    int'($urandom_range(0, 9)), int'($urandom_range(0, 8)),
                    1'($urandom), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
